// File: rtl/sha_unpadder_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | sha_pkg : shared constants and state encoding for sha_unpadder   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package sha_pkg;

  localparam int BLK_W        = 512;
  localparam int BLK_BYTES    = 64;
  localparam int LEN_W        = 64;
  localparam int LAST_BLK_MAX = 55;
  localparam int HOLD_MIN     = 56;
  localparam int HOLD_MAX     = 119;
  // Window byte where the length field begins, for both window bases.
  localparam int LEN_POS      = 120;

  localparam logic [7:0] PAD_MARK = 8'h80;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_HOLD       = 3'd1,
    S_DRAIN_FULL = 3'd2,
    S_CHECK      = 3'd3,
    S_DRAIN_LAST = 3'd4,
    S_DONE       = 3'd5
  } state_t;

endpackage
`default_nettype wire

// File: rtl/sha_unpadder_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | sha_unpadder_if : padded-block input and message-byte output bus |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
interface sha_unpadder_if;
  import sha_pkg::*;

  logic             blk_valid;
  logic             blk_ready;
  logic [BLK_W-1:0] blk_data;
  logic             blk_last;
  logic             out_valid;
  logic             out_ready;
  logic [7:0]       out_data;
  logic             out_last;
  logic             msg_done;
  logic             len_err;
  logic             pad_err;

  modport slave (
    input  blk_valid, blk_data, blk_last, out_ready,
    output blk_ready, out_valid, out_data, out_last, msg_done, len_err, pad_err
  );

  modport master (
    output blk_valid, blk_data, blk_last, out_ready,
    input  blk_ready, out_valid, out_data, out_last, msg_done, len_err, pad_err
  );

endinterface
`default_nettype wire

// File: rtl/sha_unpadder_byte_sel.sv
`default_nettype none
// +------------------------------------------------------------------+
// | sha_blk_byte_sel : picks one byte out of the 128-byte window     |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module sha_blk_byte_sel
  import sha_pkg::*;
(
  input  wire logic [2*BLK_W-1:0] i_win,
  input  wire logic [6:0]         i_idx,
  output logic      [7:0]         o_byte
);

  logic [9:0] w_lsb;

  // Byte 0 sits in the most significant bits of the window.
  assign w_lsb  = 10'(2*BLK_W - 8) - {i_idx, 3'b000};
  assign o_byte = i_win[w_lsb +: 8];

endmodule
`default_nettype wire

// File: rtl/sha_unpadder.sv
`default_nettype none
// +------------------------------------------------------------------+
// | sha_unpadder : strips SHA-256 padding from a padded block stream |
// | Optional padding check: define SHA_UNPAD_CHECK_EN                |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module sha_unpadder
  import sha_pkg::*;
#(
  parameter int CNT_W = 16
)(
  input  wire logic        clk,
  input  wire logic        rst_n,
  sha_unpadder_if.slave    bus
);

  state_t             r_state;
  logic [BLK_W-1:0]   r_buf0;
  logic [BLK_W-1:0]   r_buf1;
  logic               r_hold;
  logic [CNT_W-1:0]   r_emc;
  logic [6:0]         r_idx;
  logic [6:0]         r_rem;
  logic               r_rdy;
  logic               r_valid;
  logic               r_last;
  logic               r_done;
  logic               r_len_err;
  logic               r_pad_err;

  logic [2*BLK_W-1:0] w_win;
  logic [7:0]         w_byte;
  logic               w_blk_acc;
  logic               w_out_acc;
  logic [6:0]         w_base;
  logic [CNT_W:0]     w_r;
  logic               w_len_err;
  logic               w_pad_err;

  assign w_win     = {r_buf0, r_buf1};
  assign w_blk_acc = bus.blk_valid && r_rdy;
  assign w_out_acc = r_valid && bus.out_ready;
  assign w_base    = r_hold ? 7'd0 : 7'(BLK_BYTES);

  // Extra MSB catches a length smaller than what was already emitted.
  assign w_r = {1'b0, r_buf1[3 +: CNT_W]} - {1'b0, r_emc};

  assign w_len_err = (r_buf1[2:0] != 3'd0)
                  || (|r_buf1[LEN_W-1:3+CNT_W])
                  || w_r[CNT_W]
                  || (r_hold ? ((w_r < (CNT_W+1)'(HOLD_MIN)) || (w_r > (CNT_W+1)'(HOLD_MAX)))
                             : (w_r > (CNT_W+1)'(LAST_BLK_MAX)));

`ifdef SHA_UNPAD_CHECK_EN
  logic [7:0]         w_pos;
  logic [LEN_POS-1:0] w_bad;

  assign w_pos = {1'b0, w_base} + {1'b0, w_r[6:0]};

  for (genvar k = 0; k < LEN_POS; k++) begin : g_pad
    logic [7:0] w_b;
    assign w_b      = w_win[2*BLK_W-1-8*k -: 8];
    assign w_bad[k] = ((w_pos == 8'(k)) && (w_b != PAD_MARK))
                   || ((w_pos <  8'(k)) && (w_b != 8'h00));
  end

  assign w_pad_err = |w_bad;
`else
  assign w_pad_err = 1'b0;
`endif

  sha_blk_byte_sel u_sel (
    .i_win  (w_win),
    .i_idx  (r_idx),
    .o_byte (w_byte)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_buf0    <= '0;
      r_buf1    <= '0;
      r_hold    <= 1'b0;
      r_emc     <= '0;
      r_idx     <= '0;
      r_rem     <= '0;
      r_rdy     <= 1'b0;
      r_valid   <= 1'b0;
      r_last    <= 1'b0;
      r_done    <= 1'b0;
      r_len_err <= 1'b0;
      r_pad_err <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_rdy <= 1'b1;
          if (w_blk_acc) begin
            if (bus.blk_last) begin
              r_buf1  <= bus.blk_data;
              r_hold  <= 1'b0;
              r_rdy   <= 1'b0;
              r_state <= S_CHECK;
            end else begin
              r_buf0  <= bus.blk_data;
              r_hold  <= 1'b1;
              r_state <= S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (w_blk_acc) begin
            r_buf1 <= bus.blk_data;
            r_rdy  <= 1'b0;
            if (bus.blk_last) begin
              r_state <= S_CHECK;
            end else begin
              r_idx   <= '0;
              r_valid <= 1'b1;
              r_last  <= 1'b0;
              r_state <= S_DRAIN_FULL;
            end
          end
        end
        S_DRAIN_FULL: begin
          if (w_out_acc) begin
            if (r_idx == 7'(BLK_BYTES-1)) begin
              r_valid <= 1'b0;
              r_buf0  <= r_buf1;
              r_emc   <= r_emc + CNT_W'(BLK_BYTES);
              r_rdy   <= 1'b1;
              r_state <= S_HOLD;
            end else begin
              r_idx <= r_idx + 7'd1;
            end
          end
        end
        S_CHECK: begin
          r_len_err <= w_len_err;
          r_pad_err <= w_pad_err && !w_len_err;
          r_idx     <= w_base;
          r_rem     <= w_r[6:0];
          if (w_len_err || (w_r == '0)) begin
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_valid <= 1'b1;
            r_last  <= (w_r[6:0] == 7'd1);
            r_state <= S_DRAIN_LAST;
          end
        end
        S_DRAIN_LAST: begin
          if (w_out_acc) begin
            if (r_rem == 7'd1) begin
              r_valid <= 1'b0;
              r_last  <= 1'b0;
              r_rem   <= '0;
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_idx  <= r_idx + 7'd1;
              r_rem  <= r_rem - 7'd1;
              r_last <= (r_rem == 7'd2);
            end
          end
        end
        S_DONE: begin
          r_done    <= 1'b0;
          r_len_err <= 1'b0;
          r_pad_err <= 1'b0;
          r_emc     <= '0;
          r_hold    <= 1'b0;
          r_rdy     <= 1'b1;
          r_state   <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.blk_ready = r_rdy;
  assign bus.out_valid = r_valid;
  assign bus.out_data  = w_byte;
  assign bus.out_last  = r_last;
  assign bus.msg_done  = r_done;
  assign bus.len_err   = r_len_err;
  assign bus.pad_err   = r_pad_err;

endmodule
`default_nettype wire

// File: tb/tb_sha_unpadder.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_sha_unpadder : randomized bench with a message-level model    |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_sha_unpadder;

  typedef logic [7:0] u8;

`ifdef SHA_UNPAD_CHECK_EN
  localparam bit PAD_ON = 1'b1;
`else
  localparam bit PAD_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sha_unpadder_if bus_if();

  sha_unpadder #(.CNT_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  u8  q_bytes[$];
  bit q_last[$];
  bit q_le[$];
  bit q_pe[$];
  int first_cyc = -1;
  int done_cyc  = -1;
  int acc_cyc   = 0;
  bit throttle  = 1'b0;

  // Consumer: randomizes out_ready, records bytes and done pulses, checks stall stability.
  initial begin
    bit stall_p;
    u8  stall_d;
    bit stall_l;
    stall_p = 1'b0;
    stall_d = 8'h00;
    stall_l = 1'b0;
    bus_if.out_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall_p = 1'b0;
        continue;
      end
      if (stall_p) begin
        chk("stall_valid", 64'(bus_if.out_valid), 64'd1);
        chk("stall_data",  64'(bus_if.out_data),  64'(stall_d));
        chk("stall_last",  64'(bus_if.out_last),  64'(stall_l));
      end
      if (bus_if.out_valid)
        chk("blk_ready_during_drain", 64'(bus_if.blk_ready), 64'd0);
      bus_if.out_ready = throttle ? ($urandom_range(0, 3) != 0) : 1'b1;
      stall_p = 1'b0;
      if (bus_if.out_valid) begin
        if (first_cyc < 0) first_cyc = cyc;
        if (bus_if.out_ready) begin
          q_bytes.push_back(bus_if.out_data);
          q_last.push_back(bus_if.out_last);
        end else begin
          stall_p = 1'b1;
          stall_d = bus_if.out_data;
          stall_l = bus_if.out_last;
        end
      end
      if (bus_if.msg_done) begin
        q_le.push_back(bus_if.len_err);
        q_pe.push_back(bus_if.pad_err);
        done_cyc = cyc;
      end
    end
  end

  task automatic pad(input u8 m[$], output u8 s[$]);
    logic [63:0] bitlen;
    s = m;
    s.push_back(8'h80);
    while ((s.size() % 64) != 56) s.push_back(8'h00);
    bitlen = 64'(m.size()) * 64'd8;
    for (int i = 7; i >= 0; i--) s.push_back(bitlen[8*i +: 8]);
  endtask

  task automatic pack(input u8 s[$], output logic [511:0] blks[$]);
    logic [511:0] b;
    blks.delete();
    for (int i = 0; i < s.size() / 64; i++) begin
      for (int j = 0; j < 64; j++) b[511-8*j -: 8] = s[64*i+j];
      blks.push_back(b);
    end
  endtask

  task automatic send_block(input logic [511:0] d, input bit last);
    int t;
    t = 0;
    bus_if.blk_data  = d;
    bus_if.blk_last  = last;
    bus_if.blk_valid = 1'b1;
    @(negedge clk);
    while (!bus_if.blk_ready && t < 5000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 5000) chk("blk_ready_timeout", 64'd0, 64'd1);
    acc_cyc = cyc;
    @(posedge clk);
    #1;
    bus_if.blk_valid = 1'b0;
    bus_if.blk_last  = 1'b0;
  endtask

  task automatic clear_obs();
    q_bytes.delete();
    q_last.delete();
    q_le.delete();
    q_pe.delete();
    first_cyc = -1;
    done_cyc  = -1;
  endtask

  // Model: output is the first L stream bytes when the length field fits the block count.
  task automatic run_frame(input string tag, input u8 s[$], input bit bad_pad);
    logic [511:0]    blks[$];
    logic [63:0]     bitlen;
    longint unsigned nl;
    bit              exp_len;
    bit              exp_pad;
    u8               exp_b[$];
    int              t, bad, nlast, lastpos;
    pack(s, blks);
    bitlen = 64'd0;
    for (int i = s.size() - 8; i < s.size(); i++) bitlen = {bitlen[55:0], s[i]};
    nl      = bitlen >> 3;
    exp_len = (bitlen[2:0] != 3'd0) || (nl >= 64'd65536) || (64'(blks.size()) != (nl + 64'd72) / 64'd64);
    exp_pad = bad_pad && PAD_ON && !exp_len;
    if (!exp_len)
      for (int i = 0; i < int'(nl); i++) exp_b.push_back(s[i]);
    clear_obs();
    for (int i = 0; i < blks.size(); i++) send_block(blks[i], i == blks.size() - 1);
    t = 0;
    while (q_le.size() == 0 && t < 5000) begin
      @(negedge clk);
      t++;
    end
    chk({tag, "_done_count"}, 64'(q_le.size()), 64'd1);
    if (q_le.size() > 0) begin
      chk({tag, "_len_err"}, 64'(q_le[0]), 64'(exp_len));
      chk({tag, "_pad_err"}, 64'(q_pe[0]), 64'(exp_pad));
    end
    chk({tag, "_byte_count"}, 64'(q_bytes.size()), 64'(exp_b.size()));
    bad     = 0;
    nlast   = 0;
    lastpos = -1;
    for (int i = 0; i < q_bytes.size(); i++) begin
      if (i >= exp_b.size() || q_bytes[i] !== exp_b[i]) bad++;
      if (q_last[i]) begin
        if (lastpos < 0) lastpos = i;
        nlast++;
      end
    end
    chk({tag, "_bad_bytes"}, 64'(bad), 64'd0);
    chk({tag, "_last_count"}, 64'(nlast), (exp_b.size() > 0) ? 64'd1 : 64'd0);
    if (exp_b.size() > 0) chk({tag, "_last_pos"}, 64'(lastpos), 64'(exp_b.size() - 1));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    u8            m[$];
    u8            s[$];
    u8            s2[$];
    logic [511:0] blks[$];
    int           t;
    int           lens[$];

    bus_if.blk_valid = 1'b0;
    bus_if.blk_last  = 1'b0;
    bus_if.blk_data  = '0;

    repeat (3) @(negedge clk);
    chk("reset_outputs", 64'({bus_if.blk_ready, bus_if.out_valid, bus_if.out_last,
                              bus_if.msg_done, bus_if.len_err, bus_if.pad_err}), 64'd0);
    chk("reset_out_data", 64'(bus_if.out_data), 64'd0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("idle_blk_ready", 64'(bus_if.blk_ready), 64'd1);

    m = '{8'h61, 8'h62, 8'h63};
    pad(m, s);
    run_frame("abc", s, 1'b0);
    chk("abc_first_byte_latency", 64'(first_cyc - acc_cyc), 64'd2);

    m.delete();
    pad(m, s);
    run_frame("empty", s, 1'b0);
    chk("empty_done_latency", 64'(done_cyc - acc_cyc), 64'd2);
    chk("empty_no_valid", 64'(first_cyc < 0), 64'd1);

    m.delete();
    for (int i = 0; i < 56; i++) m.push_back(8'(i));
    pad(m, s);
    run_frame("msg56", s, 1'b0);

    m.delete();
    for (int i = 0; i < 130; i++) m.push_back(8'(i));
    pad(m, s);
    run_frame("msg130", s, 1'b0);

    m = '{8'h61, 8'h62, 8'h63};
    pad(m, s);
    s[63] = 8'h19;
    run_frame("len_0x19", s, 1'b0);

    pad(m, s);
    s2.delete();
    for (int i = 0; i < 56; i++) s2.push_back(s[i]);
    for (int i = 0; i < 64; i++) s2.push_back(8'h00);
    for (int i = 56; i < 64; i++) s2.push_back(s[i]);
    run_frame("len_2blk", s2, 1'b0);

    pad(m, s);
    s[10] = 8'h01;
    run_frame("pad_fill_bad", s, 1'b1);

    pad(m, s);
    s[3] = 8'h81;
    run_frame("pad_mark_bad", s, 1'b1);

    throttle = 1'b1;
    lens = '{0, 1, 55, 56, 63, 64, 119, 120, 127, 128};
    for (int i = 0; i < 6; i++) lens.push_back(int'($urandom_range(0, 200)));
    foreach (lens[k]) begin
      m.delete();
      for (int i = 0; i < lens[k]; i++) m.push_back(8'($urandom));
      pad(m, s);
      run_frame($sformatf("rand_len%0d", lens[k]), s, 1'b0);
    end

    m.delete();
    for (int i = 0; i < 100; i++) m.push_back(8'($urandom));
    pad(m, s);
    pack(s, blks);
    clear_obs();
    for (int i = 0; i < blks.size(); i++) send_block(blks[i], i == blks.size() - 1);
    t = 0;
    while (q_bytes.size() < 20 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    chk("midreset_reached_drain", 64'(q_bytes.size() >= 20), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midreset_outputs", 64'({bus_if.blk_ready, bus_if.out_valid, bus_if.out_last,
                                 bus_if.msg_done, bus_if.len_err, bus_if.pad_err}), 64'd0);
    repeat (2) @(negedge clk);
    clear_obs();
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("midreset_no_partial_done", 64'(q_le.size()), 64'd0);
    chk("midreset_no_bytes", 64'(q_bytes.size()), 64'd0);

    m = '{8'h61, 8'h62, 8'h63};
    pad(m, s);
    run_frame("post_reset_abc", s, 1'b0);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
